// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
//
// Contents:
//   arb_state_e    FSM state encoding (IDLE=0, GRANTED=1, LOCKED=2)
//   ArbMaxEntries  widest one-hot vector arb_oh_to_idx accepts
//   arb_oh_to_idx  one-hot to binary index (returns 0 for an all-zero vector)
package weighted_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbGranted = 2'd1,
        ArbLocked  = 2'd2
    } arb_state_e;

    localparam int unsigned ArbMaxEntries = 32;

    // OR of the indices of all set bits; exact for one-hot input and 0 for zero input.
    function automatic int unsigned arb_oh_to_idx(input logic [ArbMaxEntries-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < ArbMaxEntries; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/weighted_rr_arbiter_rr_picker.sv
// Combinational wrap-around round-robin picker.
//
// Returns the first set bit of request at or above the one-hot base position,
// wrapping from the MSB back to bit 0. Zero request gives zero winner.
//
// Ports:
//   request    in   NUM_ENTRIES  candidate vector
//   base       in   NUM_ENTRIES  one-hot highest-priority position
//   winner_oh  out  NUM_ENTRIES  one-hot winner (or zero)
module weighted_rr_arbiter_rr_picker #(
    parameter int unsigned NUM_ENTRIES = 4
) (
    input  logic [NUM_ENTRIES-1:0] request,
    input  logic [NUM_ENTRIES-1:0] base,
    output logic [NUM_ENTRIES-1:0] winner_oh
);

    logic [2*NUM_ENTRIES-1:0] req_dbl;
    logic [2*NUM_ENTRIES-1:0] masked;

    // Subtracting base borrows through the zeros above it up to the first set
    // bit; ANDing with the inverted difference isolates exactly that bit. The
    // doubled vector lets the borrow run into the upper copy to model wrap-around.
    assign req_dbl   = {request, request};
    assign masked    = req_dbl & ~(req_dbl - {{NUM_ENTRIES{1'b0}}, base});
    assign winner_oh = masked[NUM_ENTRIES-1:0] | masked[2*NUM_ENTRIES-1:NUM_ENTRIES];

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Round-robin arbiter with grant/accept handshake, burst lock and optional weights.
//
// The grant is registered and held until the grantee accepts or withdraws its
// request. After a completed grant the priority rotates so the winner goes last.
// With ARB_WEIGHT_EN defined, each requester gets weight[i] accepted grants per
// turn (0 counts as 1); otherwise every turn is a single grant.
//
// Macro: ARB_WEIGHT_EN  enables the weight port and credit loading.
//
// Ports:
//   clk          in   1                          clock
//   reset        in   1                          asynchronous, active-low
//   request      in   NUM_ENTRIES                per-requester request
//   lock         in   NUM_ENTRIES                burst lock, honoured only for the grantee
//   accept       in   1                          grantee consumed the grant
//   weight       in   NUM_ENTRIES*WEIGHT_WIDTH   grants per turn (ARB_WEIGHT_EN only)
//   grant_oh     out  NUM_ENTRIES                registered one-hot grant
//   grant_idx    out  IDX_WIDTH                  binary index of grant_oh
//   grant_valid  out  1                          |grant_oh
module weighted_rr_arbiter
    import weighted_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES  = 4,
    parameter int unsigned IDX_WIDTH    = 2,
    parameter int unsigned WEIGHT_WIDTH = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_ENTRIES-1:0]              request,
    input  logic [NUM_ENTRIES-1:0]              lock,
    input  logic                                accept,
`ifdef ARB_WEIGHT_EN
    input  logic [NUM_ENTRIES*WEIGHT_WIDTH-1:0] weight,
`endif
    output logic [NUM_ENTRIES-1:0]              grant_oh,
    output logic [IDX_WIDTH-1:0]                grant_idx,
    output logic                                grant_valid
);

    arb_state_e              state_q, state_d;
    logic [NUM_ENTRIES-1:0]  base_q, base_d;
    logic [NUM_ENTRIES-1:0]  grant_q, grant_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic [NUM_ENTRIES-1:0]  grant_rot;
    logic [NUM_ENTRIES-1:0]  pick_req;
    logic [NUM_ENTRIES-1:0]  pick_base;
    logic [NUM_ENTRIES-1:0]  winner_oh;
    logic [WEIGHT_WIDTH-1:0] win_credit;
    logic                    req_g;
    logic                    lock_g;
    logic                    take_accept;
    logic                    abandon;

    assign req_g     = |(request & grant_q);
    assign lock_g    = |(lock & grant_q);
    assign grant_rot = {grant_q[NUM_ENTRIES-2:0], grant_q[NUM_ENTRIES-1]};

    // One picker serves both cases: in IDLE grant_q is zero so the mask is a
    // no-op and base_q applies; on a handoff the old grantee is excluded and
    // priority already starts just past it.
    assign pick_req  = request & ~grant_q;
    assign pick_base = (state_q == ArbIdle) ? base_q : grant_rot;

    weighted_rr_arbiter_rr_picker #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_picker (
        .request  (pick_req),
        .base     (pick_base),
        .winner_oh(winner_oh)
    );

`ifdef ARB_WEIGHT_EN
    logic [WEIGHT_WIDTH-1:0] weight_raw;

    always_comb begin
        weight_raw = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (winner_oh[i]) begin
                weight_raw = weight_raw | weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
        win_credit = (weight_raw == '0) ? WEIGHT_WIDTH'(1) : weight_raw;
    end
`else
    assign win_credit = WEIGHT_WIDTH'(1);
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        grant_d     = grant_q;
        credit_d    = credit_q;
        take_accept = 1'b0;
        abandon     = 1'b0;

        case (state_q)
            ArbIdle: begin
                if (|request) begin
                    state_d  = ArbGranted;
                    grant_d  = winner_oh;
                    credit_d = win_credit;
                end
            end
            ArbGranted: begin
                if (accept) begin
                    if (lock_g) begin
                        state_d = ArbLocked;
                    end else begin
                        take_accept = 1'b1;
                    end
                end else if (!req_g) begin
                    abandon = 1'b1;
                end
            end
            ArbLocked: begin
                if (accept && !lock_g) begin
                    take_accept = 1'b1;
                end else if (!req_g) begin
                    abandon = 1'b1;
                end
            end
            default: begin
                state_d = ArbIdle;
                grant_d = '0;
            end
        endcase

        if (take_accept) begin
            if ((credit_q > WEIGHT_WIDTH'(1)) && req_g) begin
                state_d  = ArbGranted;
                credit_d = credit_q - WEIGHT_WIDTH'(1);
            end else begin
                base_d = grant_rot;
                if (|pick_req) begin
                    // Zero-bubble handoff to the next requester.
                    state_d  = ArbGranted;
                    grant_d  = winner_oh;
                    credit_d = win_credit;
                end else begin
                    state_d = ArbIdle;
                    grant_d = '0;
                end
            end
        end

        if (abandon) begin
            state_d = ArbIdle;
            base_d  = grant_rot;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ArbIdle;
            base_q   <= NUM_ENTRIES'(1);
            grant_q  <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
        end
    end

    assign grant_oh    = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = IDX_WIDTH'(arb_oh_to_idx(ArbMaxEntries'(grant_q)));

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Self-checking bench for weighted_rr_arbiter (N=4). A driver issues one input
// vector per cycle, steps an index-level reference model and queues the
// expected registered outputs; a monitor pops and compares after each edge.
module tb_weighted_rr_arbiter;

    localparam int N  = 4;
    localparam int WW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] lock;
    logic       accept;
    logic [3:0] grant_oh;
    logic [1:0] grant_idx;
    logic       grant_valid;
`ifdef ARB_WEIGHT_EN
    logic [N*WW-1:0] weight;
    int              w [N];
`endif

    weighted_rr_arbiter #(
        .NUM_ENTRIES (4),
        .IDX_WIDTH   (2),
        .WEIGHT_WIDTH(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .request    (request),
        .lock       (lock),
        .accept     (accept),
`ifdef ARB_WEIGHT_EN
        .weight     (weight),
`endif
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] oh;
        logic [1:0] idx;
        logic       vld;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    // Reference model: current grantee index (-1 = none), index that has top
    // priority next, remaining grants in this turn, and lock status.
    int m_g;
    int m_ptr;
    int m_credit;
    bit m_locked;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] rq, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && rq[i]) return i;
        end
        return -1;
    endfunction

    function automatic int init_credit(input int g);
`ifdef ARB_WEIGHT_EN
        return (w[g] == 0) ? 1 : w[g];
`else
        return (g >= 0) ? 1 : 1;
`endif
    endfunction

    task automatic model_reset();
        m_g      = -1;
        m_ptr    = 0;
        m_credit = 0;
        m_locked = 1'b0;
    endtask

    task automatic model_abandon();
        m_ptr    = (m_g + 1) % N;
        m_g      = -1;
        m_locked = 1'b0;
    endtask

    task automatic model_accept(input logic [3:0] rq);
        if (m_credit > 1 && rq[m_g]) begin
            m_credit--;
            m_locked = 1'b0;
        end else begin
            int nxt;
            m_ptr    = (m_g + 1) % N;
            nxt      = pick(rq, m_ptr, m_g);
            m_g      = nxt;
            m_locked = 1'b0;
            if (nxt >= 0) m_credit = init_credit(nxt);
        end
    endtask

    task automatic model_step(input logic [3:0] rq, input logic [3:0] lk, input logic ac);
        if (m_g < 0) begin
            if (rq != 4'b0) begin
                m_g      = pick(rq, m_ptr, -1);
                m_credit = init_credit(m_g);
                m_locked = 1'b0;
            end
        end else if (m_locked) begin
            if (ac && !lk[m_g]) model_accept(rq);
            else if (!rq[m_g]) model_abandon();
        end else if (ac) begin
            if (lk[m_g]) m_locked = 1'b1;
            else model_accept(rq);
        end else if (!rq[m_g]) begin
            model_abandon();
        end
    endtask

    task automatic step(input logic [3:0] rq, input logic [3:0] lk, input logic ac);
        exp_t e;
        @(negedge clk);
        request = rq;
        lock    = lk;
        accept  = ac;
`ifdef ARB_WEIGHT_EN
        for (int i = 0; i < N; i++) weight[i*WW +: WW] = WW'(w[i]);
`endif
        model_step(rq, lk, ac);
        e.vld = (m_g >= 0);
        e.oh  = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
        e.idx = (m_g >= 0) ? 2'(m_g) : 2'd0;
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    // Asserts reset away from a clock edge and checks the outputs clear at once.
    task automatic do_reset();
        if (exp_q.size() != 0) begin
            @(posedge clk);
            #2;
        end
        mon_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("async_reset_oh", grant_oh, 4'b0);
        check("async_reset_idx", grant_idx, 2'd0);
        check("async_reset_valid", grant_valid, 1'b0);
        model_reset();
        request = 4'b0;
        lock    = 4'b0;
        accept  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got none expected an entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_grant_oh", grant_oh, e.oh);
                    check("sb_grant_idx", grant_idx, e.idx);
                    check("sb_grant_valid", grant_valid, e.vld);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int fair_seq [5];
        fair_seq = '{0, 1, 2, 3, 0};

        reset   = 1'b1;
        request = 4'b0;
        lock    = 4'b0;
        accept  = 1'b0;
`ifdef ARB_WEIGHT_EN
        for (int i = 0; i < N; i++) w[i] = 1;
        weight = '0;
`endif
        model_reset();
        #2 reset = 1'b0;
        #1;
        check("reset_oh", grant_oh, 4'b0);
        check("reset_idx", grant_idx, 2'd0);
        check("reset_valid", grant_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Fairness: all requesting, accept every cycle.
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b0, 1'b1);
            @(posedge clk);
            #2;
            check("fair_seq", grant_idx, fair_seq[k]);
        end
        step(4'b0000, 4'b0, 1'b1);
        step(4'b0000, 4'b0, 1'b0);

        // Hold: grant stays while not accepted, drops after accept.
        for (int k = 0; k < 5; k++) begin
            step(4'b0100, 4'b0, 1'b0);
            @(posedge clk);
            #2;
            check("hold_stable", grant_oh, 4'b0100);
        end
        step(4'b0100, 4'b0, 1'b1);
        @(posedge clk);
        #2;
        check("hold_drop", grant_valid, 1'b0);
        step(4'b0000, 4'b0, 1'b0);

        // Lock: entry 1 holds through accepts while entry 2 waits.
        step(4'b0010, 4'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(4'b0110, 4'b0010, 1'b1);
            @(posedge clk);
            #2;
            check("lock_pinned", grant_oh, 4'b0010);
        end
        step(4'b0110, 4'b0000, 1'b1);
        @(posedge clk);
        #2;
        check("lock_handoff", grant_oh, 4'b0100);

        // Abandon and wrap: entry 3 drops its request, entry 0 wins next.
        step(4'b1000, 4'b0, 1'b1);
        @(posedge clk);
        #2;
        check("wrap_grant3", grant_idx, 2'd3);
        step(4'b0001, 4'b0, 1'b0);
        @(posedge clk);
        #2;
        check("abandon_idle", grant_valid, 1'b0);
        step(4'b0001, 4'b0, 1'b0);
        @(posedge clk);
        #2;
        check("wrap_grant0", grant_oh, 4'b0001);

        // Reset mid-grant, then lowest requester wins.
        step(4'b1111, 4'b0, 1'b0);
        step(4'b1111, 4'b0, 1'b0);
        do_reset();
        step(4'b0110, 4'b0, 1'b0);
        @(posedge clk);
        #2;
        check("post_reset_lowest", grant_oh, 4'b0010);

`ifdef ARB_WEIGHT_EN
        // Weights {1,1,1,3} for entries 3..0.
        do_reset();
        w[0] = 3;
        w[1] = 1;
        w[2] = 1;
        w[3] = 1;
        begin
            int wseq [7];
            wseq = '{0, 0, 0, 1, 2, 3, 0};
            for (int k = 0; k < 7; k++) begin
                step(4'b1111, 4'b0, 1'b1);
                @(posedge clk);
                #2;
                check("weight_seq", grant_idx, wseq[k]);
            end
        end
`endif

        // Randomised traffic against the model.
        for (int k = 0; k < 500; k++) begin
            logic [3:0] rq;
            logic [3:0] lk;
            logic       ac;
`ifdef ARB_WEIGHT_EN
            if (k % 16 == 0) begin
                for (int i = 0; i < N; i++) w[i] = int'($urandom_range(0, 7));
            end
`endif
            rq = 4'($urandom_range(0, 15));
            lk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            ac = 1'($urandom_range(0, 1));
            step(rq, lk, ac);
            if (k == 250) do_reset();
        end
        @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
